// File: rtl/multibyte_add_seq.sv
// Byte-serial add/subtract: one shared 8-bit adder walks NBYTES bytes, LSB first.
// Result, Cout and V are registered and done pulses NBYTES cycles after start; start is ignored while busy.

module adder_8bit (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  output logic [7:0] s_o,
  output logic       cout_o
);

  logic [8:0] sum;

  assign sum    = {1'b0, a_i} + {1'b0, b_i} + {8'd0, cin_i};
  assign s_o    = sum[7:0];
  assign cout_o = sum[8];

endmodule

module multibyte_add_seq #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                op_sub,
  input  logic                Cin,
  input  logic [8*NBYTES-1:0] A,
  input  logic [8*NBYTES-1:0] B,
  output logic [8*NBYTES-1:0] S,
  output logic                Cout,
  output logic                V,
  output logic                busy,
  output logic                done
);

  localparam int W    = 8 * NBYTES;
  localparam int IDXW = $clog2(NBYTES);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            sub_q, sub_d;
  logic [W-1:0]    s_q, s_d;
  logic            cout_q, cout_d;
  logic            v_q, v_d;
  logic            done_q, done_d;

  logic [7:0]      add_a;
  logic [7:0]      add_b;
  logic [7:0]      add_s;
  logic            add_cout;

  // Byte mux in front of the single shared adder; B is inverted for subtraction.
  always_comb begin
    add_a = '0;
    add_b = '0;
    for (int k = 0; k < NBYTES; k++) begin
      if (idx_q == IDXW'(k)) begin
        add_a = a_q[8*k +: 8];
        add_b = b_q[8*k +: 8];
      end
    end
    if (sub_q) begin
      add_b = ~add_b;
    end
  end

  adder_8bit u_adder (
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (carry_q),
    .s_o    (add_s),
    .cout_o (add_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    s_d     = s_q;
    cout_d  = cout_q;
    v_d     = v_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          sub_d   = op_sub;
          carry_d = Cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        for (int k = 0; k < NBYTES; k++) begin
          if (idx_q == IDXW'(k)) begin
            s_d[8*k +: 8] = add_s;
          end
        end
        carry_d = add_cout;
        if (idx_q == LAST_IDX) begin
          // Carry into bit 7 is recovered from the sum bit, so V needs no extra adder tap.
          cout_d  = add_cout;
          v_d     = add_a[7] ^ add_b[7] ^ add_s[7] ^ add_cout;
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      v_q     <= v_d;
      done_q  <= done_d;
    end
  end

  assign S    = s_q;
  assign Cout = cout_q;
  assign V    = v_q;
  assign busy = (state_q == RUN);
  assign done = done_q;

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Directed bench for multibyte_add_seq with NBYTES=4; expected values are hand-computed.
// Outputs are sampled 1ns after the rising edge.

module tb_multibyte_add_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        op_sub = 1'b0;
  logic        Cin = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [31:0] S;
  logic        Cout;
  logic        V;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;

  multibyte_add_seq #(.NBYTES(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op_sub (op_sub),
    .Cin    (Cin),
    .A      (A),
    .B      (B),
    .S      (S),
    .Cout   (Cout),
    .V      (V),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic cin);
    A      = a;
    B      = b;
    op_sub = sub;
    Cin    = cin;
    start  = 1'b1;
  endtask

  // Counts edges until done is seen (bounded), and how many of those samples had busy high.
  task automatic wait_done(output int n, output int n_busy);
    n      = 0;
    n_busy = 0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (done) break;
      if (busy) n_busy++;
    end
  endtask

  // start must already be asserted; the next rising edge is the start-sampling edge.
  task automatic finish_op(input string tag, input logic [31:0] exp_s,
                           input logic exp_c, input logic exp_v);
    int n, n_busy;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "_busy_e0"}, 64'(busy), 64'd1);
    wait_done(n, n_busy);
    check({tag, "_latency"}, 64'(n), 64'd4);
    check({tag, "_busy_cycles"}, 64'(n_busy + 1), 64'd4);
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    check({tag, "_S"}, 64'(S), 64'(exp_s));
    check({tag, "_Cout"}, 64'(Cout), 64'(exp_c));
    check({tag, "_V"}, 64'(V), 64'(exp_v));
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic cin, input logic [31:0] exp_s,
                        input logic exp_c, input logic exp_v);
    @(negedge clk);
    issue(a, b, sub, cin);
    finish_op(tag, exp_s, exp_c, exp_v);
  endtask

  initial begin
    int n, n_busy;
    bit saw_done;

    #2 rst = 1'b1;
    #1;
    check("rst_S", 64'(S), 64'd0);
    check("rst_Cout", 64'(Cout), 64'd0);
    check("rst_V", 64'(V), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_op("add_ff_1",   32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0);
    run_op("wrap",       32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
    run_op("ovf_pos",    32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
    run_op("ovf_neg",    32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1);
    run_op("sub_5_3",    32'h00000005, 32'h00000003, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0);
    run_op("sub_3_5",    32'h00000003, 32'h00000005, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);

    // start pulsed mid-run with different operands must not disturb the operation
    @(negedge clk);
    issue(32'h000000FF, 32'h00000001, 1'b0, 1'b0);
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 issue(32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b1);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(n, n_busy);
    check("ign_latency", 64'(n), 64'd2);
    check("ign_S", 64'(S), 64'h00000100);
    check("ign_Cout", 64'(Cout), 64'd0);
    check("ign_V", 64'(V), 64'd0);
    @(posedge clk);
    #1;
    check("ign_done_one_cycle", 64'(done), 64'd0);
    check("ign_S_hold", 64'(S), 64'h00000100);
    check("ign_busy_idle", 64'(busy), 64'd0);

    // back-to-back: start raised in the done cycle
    run_op("b2b_first", 32'h00000003, 32'h00000004, 1'b0, 1'b1, 32'h00000008, 1'b0, 1'b0);
    check("b2b_done_cycle", 64'(done), 64'd1);
    issue(32'h12345678, 32'h11111111, 1'b0, 1'b0);
    finish_op("b2b_second", 32'h23456789, 1'b0, 1'b0);

    // leave Cout=V=1 so the mid-run reset has something to clear
    run_op("pre_rst", 32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1);
    @(negedge clk);
    issue(32'h11223344, 32'h01010101, 1'b0, 1'b0);
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("mid_partial_S", 64'(S), 64'h00003445);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_S", 64'(S), 64'd0);
    check("mid_rst_Cout", 64'(Cout), 64'd0);
    check("mid_rst_V", 64'(V), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    saw_done = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    check("mid_rst_no_done", 64'(saw_done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("after_rst", 32'h11223344, 32'h01010101, 1'b0, 1'b0, 32'h12233445, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multibyte_add_seq.md
MULTIBYTE_ADD_SEQ -- requirements
Module: multibyte_add_seq

Interface
REQ-001 The block SHALL have parameter NBYTES, default 4, giving the operand width in bytes; legal range is 2..8.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 start  input  1  request to begin an operation; sampled only while busy=0.
REQ-006 op_sub  input  1  0 = A+B, 1 = A+~B; captured with start.
REQ-007 Cin  input  1  carry into byte 0; captured with start.
REQ-008 A  input  8*NBYTES  operand A; captured with start.
REQ-009 B  input  8*NBYTES  operand B; captured with start.
REQ-010 S  output  8*NBYTES  registered result.
REQ-011 Cout  output  1  registered carry out of the top byte.
REQ-012 V  output  1  registered signed-overflow flag.
REQ-013 busy  output  1  high while an operation is in progress.
REQ-014 done  output  1  single-cycle pulse marking a valid result.

Function
REQ-015 The block SHALL contain exactly one adder_8bit instance, time-shared over all bytes, with no other adder logic.
REQ-016 The FSM SHALL have two states: IDLE and RUN.
REQ-017 In IDLE with start=1 at a rising edge E0, the block SHALL:
- capture A, B, op_sub and Cin;
- clear the byte index to 0;
- load the carry register with Cin;
- enter RUN.
REQ-018 In RUN, each cycle the adder SHALL be driven as follows:
- adder A = captured A byte[idx];
- adder B = captured B byte[idx], inverted when op_sub=1;
- adder Cin = carry register.
REQ-019 At each RUN edge, adder S SHALL be written into S byte[idx], adder Cout SHALL be written into the carry register, and idx SHALL increment.
REQ-020 Byte k SHALL be registered at edge E(k+1); the final byte SHALL be registered at edge E(NBYTES).
REQ-021 At edge E(NBYTES) the block SHALL:
- load Cout with the final adder Cout;
- load V with (carry into bit 7 of the top byte) XOR (final adder Cout), where carry into bit 7 = A[msb] ^ B'[msb] ^ S[msb];
- set done=1 for exactly one cycle;
- clear busy;
- return to IDLE.
REQ-022 Total latency from the start-sampling edge to done SHALL be NBYTES cycles.
REQ-023 busy SHALL be 1 from edge E0 through the cycle before E(NBYTES), and 0 otherwise.
REQ-024 start SHALL be ignored while busy=1, with no effect on captured operands or sequencing.
REQ-025 start=1 in the done cycle SHALL be accepted, giving back-to-back operations with no idle cycle.
REQ-026 S, Cout and V SHALL hold their values from done until the next operation writes them; partial S bytes may change during RUN.
REQ-027 The idx counter SHALL be sized as clog2(NBYTES) and SHALL never exceed NBYTES-1.
REQ-028 Subtraction A-B SHALL require op_sub=1 and Cin=1 from the caller; in that case Cout=1 means no borrow.

Reset
REQ-029 Asserting rst SHALL immediately set, independent of clk:
- state IDLE;
- idx=0 and carry register=0;
- S=0, Cout=0, V=0;
- busy=0, done=0.
REQ-030 Reset asserted mid-RUN SHALL abort the operation with no done pulse.
REQ-031 The first start after reset deassertion SHALL be processed normally.

Verification (NBYTES=4)
REQ-032 Add: A=0x000000FF, B=0x00000001, Cin=0 -> S=0x00000100, Cout=0, V=0; done exactly 4 cycles after the start edge; busy high for 4 cycles.
REQ-033 Wrap-around: A=0xFFFFFFFF, B=0x00000001, Cin=0 -> S=0x00000000, Cout=1, V=0.
REQ-034 Overflow cases:
- A=0x7FFFFFFF, B=0x00000001, Cin=0 -> S=0x80000000, Cout=0, V=1;
- A=0x80000000, B=0x80000000 -> S=0, Cout=1, V=1.
REQ-035 Subtract (op_sub=1, Cin=1):
- 5-3 -> S=0x00000002, Cout=1, V=0;
- 3-5 -> S=0xFFFFFFFE, Cout=0, V=0.
REQ-036 Handshake sequence:
- start pulsed during RUN with different operands -> ignored, first result unchanged;
- start held high in the done cycle -> second operation begins, second done exactly 4 cycles later.
REQ-037 rst asserted mid-cycle after byte 1 of 0x11223344+0x01010101 -> all outputs 0 before the next edge and no done pulse; after release, the same operation -> S=0x12233445.
